// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache between IF and MemCtl.
// Optional hit/miss statistics counters are built when ICACHE_STAT_EN is defined.
module inst_cache #(
    parameter int IDX_LOG = 8,
    parameter int TAG_W   = 16 - IDX_LOG
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        ret_flg,
    output logic [31:0] ret_inst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_flg,
    input  logic [31:0] mem_res,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int LINES = 1 << IDX_LOG;

    typedef enum logic {
        IDLE,
        MISS
    } state_e;

    state_e             state_q;
    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [31:0]        data_q [LINES];

    logic               ret_flg_q;
    logic [31:0]        ret_inst_q;
    logic               mem_req_q;
    logic [31:0]        mem_addr_q;

    logic [IDX_LOG-1:0] req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [IDX_LOG-1:0] fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic               lookup_hit;
    logic               accept;
    logic               fill_en;
    logic               unused_addr_bits;

    assign req_idx  = if_addr[IDX_LOG+1:2];
    assign req_tag  = if_addr[17:IDX_LOG+2];
    // The outstanding miss address doubles as the fill address.
    assign fill_idx = mem_addr_q[IDX_LOG+1:2];
    assign fill_tag = mem_addr_q[17:IDX_LOG+2];

    assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    // ret_flg_q blocks acceptance, forcing one bubble between responses.
    assign accept     = (state_q == IDLE) && if_req && !ret_flg_q && !reset;
    assign fill_en    = !rst && rdy && !reset && (state_q == MISS) && mem_flg;

    assign unused_addr_bits = ^if_addr[1:0];

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            ret_flg_q  <= 1'b0;
            ret_inst_q <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else if (rdy) begin
            ret_flg_q <= 1'b0;
            if (reset) begin
                state_q   <= IDLE;
                mem_req_q <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (accept && lookup_hit) begin
                            ret_flg_q  <= 1'b1;
                            ret_inst_q <= data_q[req_idx];
                        end else if (accept) begin
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= {if_addr[31:2], 2'b00};
                            state_q    <= MISS;
                        end
                    end
                    MISS: begin
                        if (mem_flg) begin
                            valid_q[fill_idx] <= 1'b1;
                            mem_req_q         <= 1'b0;
                            ret_flg_q         <= 1'b1;
                            ret_inst_q        <= mem_res;
                            state_q           <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // NOTE: tag and data arrays are not reset; a line is only trusted once
    // its valid bit is set, so clearing valid_q alone invalidates the cache.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mem_res;
        end
    end

    assign ret_flg  = ret_flg_q;
    assign ret_inst = ret_inst_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Misses count at acceptance, so flushed misses are included.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (rdy && accept) begin
            if (lookup_hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule
